mdu_ctrl: RTL

- Multi-cycle multiply/divide controller for the 5-stage MIPS pipeline (P6 extension of `mips`).
- Sits in the E stage. Sequences MULT/MULTU/DIV/DIVU over a fixed latency, owns the HI/LO registers, and serves MTHI/MTLO writes.
- Produces the stall request the hazard unit ORs into its freeze of the F/D stages.

---
 rtl/mdu_ctrl_pkg.sv | 41 ++++
 rtl/md_compute.sv | 74 +++++++
 rtl/mdu_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - shared op encodings, FSM state type and op-class helpers for the MDU
//
// Purpose : Op codes seen on mdu_ctrl.op, the controller state type, and helpers
//           that classify an op as multiply-class or divide-class.
// Macro   : MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU to the multiply class.
package mdu_ctrl_pkg;

  localparam logic [3:0] MD_MULT  = 4'd0;
  localparam logic [3:0] MD_MULTU = 4'd1;
  localparam logic [3:0] MD_DIV   = 4'd2;
  localparam logic [3:0] MD_DIVU  = 4'd3;
  localparam logic [3:0] MD_MTHI  = 4'd4;
  localparam logic [3:0] MD_MTLO  = 4'd5;
  localparam logic [3:0] MD_MADD  = 4'd6;
  localparam logic [3:0] MD_MADDU = 4'd7;
  localparam logic [3:0] MD_MSUB  = 4'd8;
  localparam logic [3:0] MD_MSUBU = 4'd9;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      MD_MULT, MD_MULTU: r = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_compute.sv
// rtl/md_compute.sv - combinational HI/LO result generator for the MDU
//
// Purpose : Computes the {hi,lo} result of the latched op/operands. Owns the
//           divide-by-zero and signed-overflow rules.
// Ports   : op     - latched op code
//           a, b   - latched rs / rt operands
//           acc    - {hi,lo} captured at the start edge (MDU_MADD_EN only)
//           res_hi - result for HI
//           res_lo - result for LO
// Macro   : MDU_MADD_EN enables the multiply-accumulate/subtract ops.
module md_compute
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MDU_MADD_EN
  input  logic [63:0] acc,
`endif
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] sprod;
  logic [63:0] uprod;
  logic        div_zero;
  logic        div_ovf;
  logic [31:0] b_safe;
  logic [31:0] sq, sr, uq, ur;
  logic [63:0] res;

  assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign uprod = {32'd0, a} * {32'd0, b};

  assign div_zero = (b == 32'd0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // The special cases are muxed out below; a harmless divisor keeps the
  // dividers away from /0 and INT_MIN/-1.
  assign b_safe = (div_zero || div_ovf) ? 32'd1 : b;

  assign sq = $signed(a) / $signed(b_safe);
  assign sr = $signed(a) % $signed(b_safe);
  assign uq = a / b_safe;
  assign ur = a % b_safe;

  always_comb begin
    res = 64'd0;
    case (op)
      MD_MULT:  res = sprod;
      MD_MULTU: res = uprod;
      MD_DIV: begin
        if (div_zero)     res = {a, 32'hFFFF_FFFF};
        else if (div_ovf) res = {32'd0, 32'h8000_0000};
        else              res = {sr, sq};
      end
      MD_DIVU: begin
        if (div_zero) res = {a, 32'hFFFF_FFFF};
        else          res = {ur, uq};
      end
`ifdef MDU_MADD_EN
      MD_MADD:  res = acc + sprod;
      MD_MADDU: res = acc + uprod;
      MD_MSUB:  res = acc - sprod;
      MD_MSUBU: res = acc - uprod;
`endif
      default:  res = 64'd0;
    endcase
  end

  assign res_hi = res[63:32];
  assign res_lo = res[31:0];

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle multiply/divide controller with HI/LO registers
//
// Purpose : E-stage MDU. Sequences mult/div ops over a fixed latency, owns
//           HI/LO, serves MTHI/MTLO, and raises stall for MDU instructions
//           that reach E while an op is in flight.
// Ports   : clk, reset     - clock, synchronous active-high reset
//           start, op      - E-stage MDU instruction valid / op code
//           a, b           - rs / rt operands
//           md_use         - E-stage instruction is any MDU instruction
//           busy, stall    - op in flight / freeze request (md_use & busy)
//           hi, lo         - HI / LO registers
// Macro   : MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (multiply latency).
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] res_hi, res_lo;
  logic        idle_start;
  logic        launch;
`ifdef MDU_MADD_EN
  logic [63:0] acc_q;
`endif

  assign idle_start = start && (state == S_IDLE);
  assign launch     = idle_start && (is_mul_op(op) || is_div_op(op));
  assign busy       = (state == S_BUSY);
  assign stall      = md_use & busy;

  md_compute u_compute (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
`ifdef MDU_MADD_EN
    .acc    (acc_q),
`endif
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (launch) state_nx = S_BUSY;
      S_BUSY:  if (cnt == 4'd1) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= 4'd0;
      hi   <= 32'd0;
      lo   <= 32'd0;
      op_q <= 4'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
`ifdef MDU_MADD_EN
      acc_q <= 64'd0;
`endif
    end else begin
      if (launch) begin
        cnt  <= is_mul_op(op) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
`ifdef MDU_MADD_EN
        acc_q <= {hi, lo};
`endif
      end else if (state == S_BUSY) begin
        cnt <= cnt - 4'd1;
        // Final busy cycle: commit the result on this edge so it is
        // visible in the first cycle busy is low.
        if (cnt == 4'd1) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end

      if (idle_start && (op == MD_MTHI)) hi <= a;
      if (idle_start && (op == MD_MTLO)) lo <= a;
    end
  end

endmodule
